// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding, error bit indices and default widths for the divider sequencer
package div_pkg;

   localparam int NW_DEFAULT = 16;
   localparam int DW_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } seq_state_t;

   localparam int ERR_OV  = 0;
   localparam int ERR_DBZ = 1;
   localparam int ERR_TO  = 2;

endpackage

// File: rtl/op_fifo.sv
// rtl/op_fifo.sv - operand FIFO, show-ahead read, pushes refused when full, pops refused when empty
module op_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rptr];

   // Pointers are AW bits wide, so DEPTH being a power of two gives the wrap for free.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end

endmodule

// File: rtl/div_op_sequencer.sv
// rtl/div_op_sequencer.sv - queues operand pairs, drives the divider one op at a time, holds each result for the consumer
module div_op_sequencer
   import div_pkg::*;
#(
   parameter int NW      = NW_DEFAULT,
   parameter int DW      = DW_DEFAULT,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [NW-1:0] in_dividend,
   input  logic [DW-1:0] in_divisor,
   output logic          div_start,
   output logic [NW-1:0] div_dividend,
   output logic [DW-1:0] div_divisor,
   input  logic          div_done,
   input  logic [DW-1:0] div_quot,
   input  logic [DW-1:0] div_rem,
   input  logic          div_ov,
   input  logic          div_dbz,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [DW-1:0] res_quot,
   output logic [DW-1:0] res_rem,
   output logic [2:0]    res_err,
   output logic          busy
);

   localparam int CW = $clog2(TIMEOUT + 1);

   seq_state_t         state;
   seq_state_t         state_nxt;
   logic               fifo_full;
   logic               fifo_empty;
   logic               push;
   logic               pop;
   logic [NW+DW-1:0]   fifo_rdata;
   logic [CW-1:0]      wait_cnt;
   logic               timeout_hit;
   logic [2:0]         done_err;
   logic [2:0]         to_err;

   assign in_ready    = !fifo_full;
   assign push        = in_valid && !fifo_full;
   // Pop only when the FSM is about to enter ISSUE, so the popped pair lands in the operand registers.
   assign pop         = !fifo_empty && ((state == IDLE) || (state == HOLD && res_ready));
   assign timeout_hit = (wait_cnt == CW'(TIMEOUT - 1));

   op_fifo #(
      .WIDTH (NW + DW),
      .DEPTH (DEPTH)
   ) u_op_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata ({in_dividend, in_divisor}),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!fifo_empty) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (div_done || timeout_hit) state_nxt = HOLD;
         HOLD:    if (res_ready) state_nxt = fifo_empty ? IDLE : ISSUE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      div_start = (state == ISSUE);
      busy      = (state != IDLE) || !fifo_empty;
   end

   always_comb begin
      done_err          = '0;
      done_err[ERR_OV]  = div_ov;
      done_err[ERR_DBZ] = div_dbz;
      to_err            = '0;
      to_err[ERR_TO]    = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_dividend <= '0;
         div_divisor  <= '0;
      end else if (pop) begin
         {div_dividend, div_divisor} <= fifo_rdata;
      end
   end

   // Watchdog: cleared on the start pulse, counts every WAIT cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                wait_cnt <= '0;
      else if (state == ISSUE) wait_cnt <= '0;
      else if (state == WAIT)  wait_cnt <= wait_cnt + 1'b1;
   end

   // A done pulse outside WAIT never reaches these registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         res_valid <= 1'b0;
         res_quot  <= '0;
         res_rem   <= '0;
         res_err   <= '0;
      end else if (state == WAIT && div_done) begin
         res_valid <= 1'b1;
         res_quot  <= div_quot;
         res_rem   <= div_rem;
         res_err   <= done_err;
      end else if (state == WAIT && timeout_hit) begin
         res_valid <= 1'b1;
         res_quot  <= '0;
         res_rem   <= '0;
         res_err   <= to_err;
      end else if (state == HOLD && res_ready) begin
         res_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_div_op_sequencer.sv
// tb/tb_div_op_sequencer.sv - directed bench with a behavioural divider model and result scoreboard
module tb_div_op_sequencer;

   localparam int NW      = 16;
   localparam int DW      = 8;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 64;
   localparam int LAT     = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [NW-1:0] in_dividend = '0;
   logic [DW-1:0] in_divisor = '0;
   logic          div_start;
   logic [NW-1:0] div_dividend;
   logic [DW-1:0] div_divisor;
   logic          div_done = 1'b0;
   logic [DW-1:0] div_quot = '0;
   logic [DW-1:0] div_rem = '0;
   logic          div_ov = 1'b0;
   logic          div_dbz = 1'b0;
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic [DW-1:0] res_quot;
   logic [DW-1:0] res_rem;
   logic [2:0]    res_err;
   logic          busy;

   always #5 clk = ~clk;

   div_op_sequencer #(
      .NW (NW), .DW (DW), .DEPTH (DEPTH), .TIMEOUT (TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_dividend  (in_dividend),
      .in_divisor   (in_divisor),
      .div_start    (div_start),
      .div_dividend (div_dividend),
      .div_divisor  (div_divisor),
      .div_done     (div_done),
      .div_quot     (div_quot),
      .div_rem      (div_rem),
      .div_ov       (div_ov),
      .div_dbz      (div_dbz),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_quot     (res_quot),
      .res_rem      (res_rem),
      .res_err      (res_err),
      .busy         (busy)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Divider model and monitor share one negedge process so their ordering is fixed.
   int          cyc = 0;
   int          start_cnt = 0;
   int          start_cyc = 0;
   int          rise_cyc = 0;
   int          done_cyc = 0;
   int          push_cyc = 0;
   logic        rv_prev = 1'b0;
   logic [15:0] m_a = '0;
   logic [15:0] m_b = '0;
   logic [15:0] m_qf;
   logic [15:0] m_rf;
   int          m_cnt = 0;
   bit          model_en = 1'b1;
   int          inj_req = 0;
   int          inj_ack = 0;
   logic [18:0] res_q [$];

   always @(negedge clk) begin
      cyc++;
      if (res_valid && !rv_prev) rise_cyc = cyc;
      rv_prev = res_valid;
      if (res_valid && res_ready) res_q.push_back({res_quot, res_rem, res_err});
      div_done = 1'b0;
      div_ov   = 1'b0;
      div_dbz  = 1'b0;
      if (!rst) begin
         m_cnt = 0;
      end else begin
         if (div_start) begin
            start_cnt++;
            start_cyc = cyc;
            m_a   = div_dividend;
            m_b   = {8'd0, div_divisor};
            m_cnt = LAT;
         end else if (m_cnt != 0) begin
            m_cnt--;
            if (m_cnt == 0 && model_en) begin
               div_done = 1'b1;
               done_cyc = cyc;
               if (m_b == 16'd0) begin
                  div_dbz  = 1'b1;
                  div_quot = 8'hFF;
                  div_rem  = m_a[7:0];
               end else begin
                  m_qf     = m_a / m_b;
                  m_rf     = m_a % m_b;
                  div_ov   = (m_qf > 16'd255);
                  div_quot = m_qf[7:0];
                  div_rem  = m_rf[7:0];
               end
            end
         end
         if (inj_req != inj_ack) begin
            inj_ack  = inj_req;
            div_done = 1'b1;
            div_quot = 8'hAA;
            div_rem  = 8'h55;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] a, input logic [7:0] b);
      int w = 0;
      in_valid    = 1'b1;
      in_dividend = a;
      in_divisor  = b;
      @(negedge clk);
      while (!in_ready && w < 200) begin
         w++;
         @(negedge clk);
      end
      check_eq("push_accept", in_ready, 1);
      @(posedge clk);
      #1;
      push_cyc = cyc;
      in_valid = 1'b0;
   endtask

   task automatic wait_res(input int n);
      int w = 0;
      while (res_q.size() < n && w < 1000) begin
         tick(1);
         w++;
      end
      check_eq("res_count", res_q.size(), n);
   endtask

   task automatic check_res(input string tag, input logic [7:0] q, input logic [7:0] r, input logic [2:0] e);
      logic [18:0] v;
      v = 19'h7FFFF;
      if (res_q.size() > 0) v = res_q.pop_front();
      check_eq({tag, "_quot"}, v[18:11], q);
      check_eq({tag, "_rem"},  v[10:3],  r);
      check_eq({tag, "_err"},  v[2:0],   e);
   endtask

   logic [15:0] a_tab [6] = '{16'd200, 16'd255, 16'd99, 16'd500, 16'd77, 16'd1234};
   logic [7:0]  b_tab [6] = '{8'd7, 8'd16, 8'd10, 8'd25, 8'd5, 8'd99};
   logic [7:0]  q_tab [6] = '{8'd28, 8'd15, 8'd9, 8'd20, 8'd15, 8'd12};
   logic [7:0]  r_tab [6] = '{8'd4, 8'd15, 8'd9, 8'd0, 8'd2, 8'd46};

   initial begin
      int s0;
      int idx;
      bit acc;

      tick(3);
      check_eq("rst_in_ready",  in_ready, 1);
      check_eq("rst_res_valid", res_valid, 0);
      check_eq("rst_busy",      busy, 0);
      check_eq("rst_div_start", div_start, 0);
      check_eq("rst_res_err",   res_err, 0);
      check_eq("rst_res_quot",  res_quot, 0);
      check_eq("rst_dividend",  div_dividend, 0);
      rst = 1'b1;
      tick(1);

      res_ready = 1'b1;
      s0 = start_cnt;
      push(16'd100, 8'd7);
      wait_res(1);
      check_res("basic", 8'd14, 8'd2, 3'b000);
      check_eq("basic_starts",    start_cnt - s0, 1);
      check_eq("start_latency",   start_cyc - push_cyc, 2);
      check_eq("result_latency",  rise_cyc - done_cyc, 1);
      tick(3);
      check_eq("basic_busy_idle", busy, 0);

      push(16'd1000, 8'd3);
      wait_res(1);
      check_res("ovf", 8'd77, 8'd1, 3'b001);

      push(16'd50, 8'd0);
      push(16'd81, 8'd9);
      wait_res(2);
      check_res("dbz", 8'd255, 8'd50, 3'b010);
      check_res("after_dbz", 8'd9, 8'd0, 3'b000);
      tick(5);

      res_ready = 1'b0;
      s0  = start_cnt;
      idx = 0;
      for (int c = 0; c < 30; c++) begin
         in_valid    = (idx < 6);
         in_dividend = a_tab[idx % 6];
         in_divisor  = b_tab[idx % 6];
         @(negedge clk);
         acc = in_valid && in_ready;
         tick(1);
         if (acc) idx++;
      end
      check_eq("bp_accepted",      idx, 5);
      check_eq("bp_in_ready_low",  in_ready, 0);
      check_eq("bp_one_start",     start_cnt - s0, 1);
      check_eq("bp_hold_valid",    res_valid, 1);
      check_eq("bp_hold_quot",     res_quot, 28);
      check_eq("bp_hold_rem",      res_rem, 4);
      res_ready = 1'b1;
      for (int c = 0; c < 400; c++) begin
         if (idx == 6 && res_q.size() >= 6) break;
         in_valid    = (idx < 6);
         in_dividend = a_tab[idx % 6];
         in_divisor  = b_tab[idx % 6];
         @(negedge clk);
         acc = in_valid && in_ready;
         tick(1);
         if (acc) idx++;
      end
      in_valid = 1'b0;
      check_eq("bp_all_accepted", idx, 6);
      check_eq("bp_res_count", res_q.size(), 6);
      for (int i = 0; i < 6; i++) check_res($sformatf("bp%0d", i), q_tab[i], r_tab[i], 3'b000);
      check_eq("bp_starts", start_cnt - s0, 6);
      tick(5);

      model_en = 1'b0;
      s0 = start_cnt;
      push(16'd60, 8'd6);
      wait_res(1);
      check_res("timeout", 8'd0, 8'd0, 3'b100);
      check_eq("timeout_wait_cycles", rise_cyc - start_cyc - 1, TIMEOUT);
      tick(1);
      inj_req++;
      tick(10);
      check_eq("late_done_no_result", res_q.size(), 0);
      check_eq("late_done_valid",     res_valid, 0);
      check_eq("late_done_starts",    start_cnt - s0, 1);
      check_eq("late_done_busy",      busy, 0);

      push(16'd10, 8'd2);
      push(16'd20, 8'd2);
      push(16'd30, 8'd2);
      tick(3);
      check_eq("pre_rst_busy", busy, 1);
      s0 = start_cnt;
      rst = 1'b0;
      #1;
      check_eq("mid_rst_busy",      busy, 0);
      check_eq("mid_rst_in_ready",  in_ready, 1);
      check_eq("mid_rst_res_valid", res_valid, 0);
      check_eq("mid_rst_res_err",   res_err, 0);
      check_eq("mid_rst_div_start", div_start, 0);
      check_eq("mid_rst_dividend",  div_dividend, 0);
      check_eq("mid_rst_divisor",   div_divisor, 0);
      tick(2);
      rst = 1'b1;
      tick(10);
      check_eq("post_rst_no_start", start_cnt - s0, 0);
      check_eq("post_rst_busy",     busy, 0);
      model_en = 1'b1;
      push(16'd42, 8'd6);
      wait_res(1);
      check_res("post_rst", 8'd7, 8'd0, 3'b000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, %0d failures so far", n_fail);
      $fatal(1);
   end

endmodule
